ram_arbiter: RTL and testbench

Shares the single RAM port between the icache and dcache of every core. It accepts one outstanding request per cache, grants exactly one at a time, drives the RAM with the granted request, and returns data/completion through the per-cache wait/load signals. It sits between the caches' cache_control signals and the RAM model, in the position of the memory controller.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/ram_arbiter_if.sv | 35 +++
 rtl/ram_arbiter_rr_picker.sv | 42 ++++
 rtl/ram_arbiter.sv | 105 ++++++++++
 tb/tb_ram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM word and status, plus the RAM arbiter's state and requester index.
package cpu_types_pkg;

    localparam int WORD_W    = 32;
    localparam int CPU_COUNT = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Requester 2c is dcache c, requester 2c+1 is icache c.
    typedef logic [$clog2(2*CPU_COUNT)-1:0] req_idx_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Cache-side request/response signals and the single RAM port shared by all caches.
interface ram_arbiter_if #(parameter int CPUS = 2);
    import cpu_types_pkg::*;

    logic      [CPUS-1:0] iREN;
    word_t     [CPUS-1:0] iaddr;
    logic      [CPUS-1:0] iwait;
    word_t     [CPUS-1:0] iload;

    logic      [CPUS-1:0] dREN;
    logic      [CPUS-1:0] dWEN;
    word_t     [CPUS-1:0] daddr;
    word_t     [CPUS-1:0] dstore;
    logic      [CPUS-1:0] dwait;
    word_t     [CPUS-1:0] dload;

    logic                 ramREN;
    logic                 ramWEN;
    word_t                ramaddr;
    word_t                ramstore;
    word_t                ramload;
    ramstate_t            ramstate;

    // The arbiter is master of the RAM port and responder to the caches.
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin pick: cores scanned from rr upward with wrap, dcache before icache in a core.
module rr_picker #(
    parameter  int CPUS  = 2,
    localparam int NREQ  = 2*CPUS,
    localparam int IDX_W = $clog2(NREQ),
    localparam int RR_W  = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [RR_W-1:0]  rr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        // First pass covers cores rr..CPUS-1, second pass the wrapped cores 0..rr-1.
        for (int j = 0; j < CPUS; j++) begin
            if (!valid && (j >= int'(rr))) begin
                if (req[2*j]) begin
                    winner = IDX_W'(2*j);
                    valid  = 1'b1;
                end else if (req[2*j+1]) begin
                    winner = IDX_W'(2*j+1);
                    valid  = 1'b1;
                end
            end
        end
        for (int j = 0; j < CPUS; j++) begin
            if (!valid && (j < int'(rr))) begin
                if (req[2*j]) begin
                    winner = IDX_W'(2*j);
                    valid  = 1'b1;
                end else if (req[2*j+1]) begin
                    winner = IDX_W'(2*j+1);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between every core's icache and dcache; one granted access at a time.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.master bus
);

    localparam int NREQ  = 2*CPUS;
    localparam int IDX_W = $clog2(NREQ);
    localparam int RR_W  = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [RR_W-1:0]  rr;

    logic [NREQ-1:0]  req;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [RR_W-1:0]  oc;
    logic             owner_is_i;
    logic [RR_W-1:0]  next_rr;

    always_comb begin
        req = '0;
        for (int c = 0; c < CPUS; c++) begin
            req[2*c]   = bus.dREN[c] | bus.dWEN[c];
            req[2*c+1] = bus.iREN[c];
        end
    end

    rr_picker #(.CPUS(CPUS)) u_picker (
        .req    (req),
        .rr     (rr),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    assign oc         = owner[IDX_W-1:1];
    assign owner_is_i = owner[0];
    assign next_rr    = (oc == RR_W'(CPUS-1)) ? '0 : oc + 1'b1;

    // ACCESS is checked before the abandon test so a completing owner never counts as abandoned.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            owner <= '0;
            rr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner <= pick_idx;
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (bus.ramstate == ACCESS) begin
                        rr    <= next_rr;
                        state <= IDLE;
                    end else if (!req[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM drive and waits follow the registered owner, so async reset quiets them at once.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        for (int c = 0; c < CPUS; c++) begin
            bus.iload[c] = bus.ramload;
            bus.dload[c] = bus.ramload;
        end
        if (state == SERVE) begin
            if (owner_is_i) begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr[oc];
            end else begin
                bus.ramWEN   = bus.dWEN[oc];
                bus.ramREN   = bus.dREN[oc] & ~bus.dWEN[oc];
                bus.ramaddr  = bus.daddr[oc];
                bus.ramstore = bus.dstore[oc];
            end
            if (bus.ramstate == ACCESS) begin
                if (owner_is_i) begin
                    bus.iwait[oc] = 1'b0;
                end else begin
                    bus.dwait[oc] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small latency-programmable RAM model.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;

    logic  CLK = 1'b0;
    logic  nRST;
    int    checks   = 0;
    int    failures = 0;
    int    ram_cnt  = 0;
    int    ram_lat  = 2;
    logic  ram_err  = 1'b0;
    word_t ram_data = '0;

    ram_arbiter_if #(.CPUS(CPUS)) bus();

    ram_arbiter #(.CPUS(CPUS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // RAM model: ACCESS once the enable has been held for ram_lat cycles.
    always @(posedge CLK) ram_cnt <= (bus.ramREN | bus.ramWEN) ? ram_cnt + 1 : 0;

    always_comb begin
        if (!(bus.ramREN | bus.ramWEN)) bus.ramstate = FREE;
        else if (ram_err)               bus.ramstate = ERROR;
        else if (ram_cnt >= ram_lat)    bus.ramstate = ACCESS;
        else                            bus.ramstate = BUSY;
    end

    assign bus.ramload = ram_data;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic clear_reqs();
        bus.iREN   = '0;
        bus.dREN   = '0;
        bus.dWEN   = '0;
        bus.iaddr  = '0;
        bus.daddr  = '0;
        bus.dstore = '0;
    endtask

    task automatic do_reset();
        nRST    = 1'b0;
        ram_err = 1'b0;
        clear_reqs();
        repeat (2) tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.iREN = '1;
        bus.dWEN = '1;
        bus.daddr[0] = 32'h123;
        bus.dstore[0] = 32'h456;
        repeat (2) tick();
        sample();
        checks++; if (bus.ramREN !== 1'b0) begin failures++; $display("FAIL reset_ramREN got=%0b exp=0", bus.ramREN); end
        checks++; if (bus.ramWEN !== 1'b0) begin failures++; $display("FAIL reset_ramWEN got=%0b exp=0", bus.ramWEN); end
        checks++; if (bus.ramaddr !== 32'h0) begin failures++; $display("FAIL reset_ramaddr got=%h exp=0", bus.ramaddr); end
        checks++; if (bus.ramstore !== 32'h0) begin failures++; $display("FAIL reset_ramstore got=%h exp=0", bus.ramstore); end
        checks++; if (bus.iwait !== 2'b11) begin failures++; $display("FAIL reset_iwait got=%b exp=11", bus.iwait); end
        checks++; if (bus.dwait !== 2'b11) begin failures++; $display("FAIL reset_dwait got=%b exp=11", bus.dwait); end
        tick();
        clear_reqs();
        nRST = 1'b1;
        sample();
        checks++; if (bus.ramREN !== 1'b0) begin failures++; $display("FAIL reset_idle_ramREN got=%0b exp=0", bus.ramREN); end
    endtask

    task automatic test_single_read();
        do_reset();
        ram_lat  = 2;
        ram_data = 32'hDEADBEEF;
        bus.iREN[0]  = 1'b1;
        bus.iaddr[0] = 32'h40;
        sample();
        checks++; if (bus.ramREN !== 1'b0) begin failures++; $display("FAIL rd_c0_ramREN got=%0b exp=0", bus.ramREN); end
        tick(); sample();
        checks++; if (bus.ramREN !== 1'b1) begin failures++; $display("FAIL rd_c1_ramREN got=%0b exp=1", bus.ramREN); end
        checks++; if (bus.ramaddr !== 32'h40) begin failures++; $display("FAIL rd_c1_ramaddr got=%h exp=40", bus.ramaddr); end
        checks++; if (bus.iwait !== 2'b11) begin failures++; $display("FAIL rd_c1_iwait got=%b exp=11", bus.iwait); end
        tick(); sample();
        checks++; if (bus.iwait !== 2'b11) begin failures++; $display("FAIL rd_c2_iwait got=%b exp=11", bus.iwait); end
        tick(); sample();
        checks++; if (bus.iwait !== 2'b10) begin failures++; $display("FAIL rd_c3_iwait got=%b exp=10", bus.iwait); end
        checks++; if (bus.iload[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_c3_iload got=%h exp=deadbeef", bus.iload[0]); end
        checks++; if (bus.dwait !== 2'b11) begin failures++; $display("FAIL rd_c3_dwait got=%b exp=11", bus.dwait); end
        tick();
        bus.iREN[0] = 1'b0;
        sample();
        checks++; if (bus.ramREN !== 1'b0) begin failures++; $display("FAIL rd_c4_ramREN got=%0b exp=0", bus.ramREN); end
        checks++; if (bus.iwait !== 2'b11) begin failures++; $display("FAIL rd_c4_iwait got=%b exp=11", bus.iwait); end
    endtask

    task automatic test_same_core_conflict();
        int d_done, i_done, d_at, i_at;
        logic drop_d, drop_i;
        d_done = 0; i_done = 0; d_at = -1; i_at = -1;
        do_reset();
        ram_lat = 1;
        bus.dWEN[0]   = 1'b1;
        bus.daddr[0]  = 32'h100;
        bus.dstore[0] = 32'h12345678;
        bus.iREN[0]   = 1'b1;
        bus.iaddr[0]  = 32'h200;
        for (int cyc = 0; cyc < 20; cyc++) begin
            sample();
            if (cyc == 1) begin
                checks++; if ({bus.ramWEN, bus.ramREN} !== 2'b10) begin failures++; $display("FAIL conf_wr_enables got=%b exp=10", {bus.ramWEN, bus.ramREN}); end
                checks++; if (bus.ramaddr !== 32'h100) begin failures++; $display("FAIL conf_wr_addr got=%h exp=100", bus.ramaddr); end
                checks++; if (bus.ramstore !== 32'h12345678) begin failures++; $display("FAIL conf_wr_store got=%h exp=12345678", bus.ramstore); end
            end
            if (cyc == 4) begin
                checks++; if ({bus.ramWEN, bus.ramREN} !== 2'b01) begin failures++; $display("FAIL conf_rd_enables got=%b exp=01", {bus.ramWEN, bus.ramREN}); end
                checks++; if (bus.ramaddr !== 32'h200) begin failures++; $display("FAIL conf_rd_addr got=%h exp=200", bus.ramaddr); end
            end
            drop_d = !bus.dwait[0];
            drop_i = !bus.iwait[0];
            if (drop_d) begin d_done++; d_at = cyc; end
            if (drop_i) begin i_done++; i_at = cyc; end
            tick();
            if (drop_d) bus.dWEN[0] = 1'b0;
            if (drop_i) bus.iREN[0] = 1'b0;
        end
        checks++; if (d_done !== 1) begin failures++; $display("FAIL conf_dwait_drops got=%0d exp=1", d_done); end
        checks++; if (i_done !== 1) begin failures++; $display("FAIL conf_iwait_drops got=%0d exp=1", i_done); end
        checks++; if (d_at !== 2) begin failures++; $display("FAIL conf_d_cycle got=%0d exp=2", d_at); end
        checks++; if (i_at !== 5) begin failures++; $display("FAIL conf_i_cycle got=%0d exp=5", i_at); end
        clear_reqs();
    endtask

    task automatic test_cross_core_fairness();
        int order [4];
        int n, multi, addr_bad, k;
        logic [3:0] lows;
        word_t exp_addr;
        n = 0; multi = 0; addr_bad = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        do_reset();
        ram_lat = 1;
        bus.dREN = 2'b11;
        bus.iREN = 2'b11;
        bus.daddr[0] = 32'h1000;
        bus.daddr[1] = 32'h2000;
        bus.iaddr[0] = 32'h3000;
        bus.iaddr[1] = 32'h4000;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            sample();
            lows = ~{bus.iwait[1], bus.dwait[1], bus.iwait[0], bus.dwait[0]};
            k = -1;
            case (lows)
                4'b0000: k = -1;
                4'b0001: k = 0;
                4'b0010: k = 1;
                4'b0100: k = 2;
                4'b1000: k = 3;
                default: multi++;
            endcase
            if (k >= 0) begin
                case (k)
                    0: exp_addr = 32'h1000;
                    1: exp_addr = 32'h3000;
                    2: exp_addr = 32'h2000;
                    default: exp_addr = 32'h4000;
                endcase
                if (bus.ramaddr !== exp_addr) addr_bad++;
                order[n] = k;
                n++;
            end
            tick();
            case (k)
                0: bus.dREN[0] = 1'b0;
                1: bus.iREN[0] = 1'b0;
                2: bus.dREN[1] = 1'b0;
                3: bus.iREN[1] = 1'b0;
                default: ;
            endcase
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL rr_grant_count got=%0d exp=4 (cycle budget)", n); end
        checks++; if (order[0] !== 0) begin failures++; $display("FAIL rr_order0 got=%0d exp=0 (d0)", order[0]); end
        checks++; if (order[1] !== 2) begin failures++; $display("FAIL rr_order1 got=%0d exp=2 (d1)", order[1]); end
        checks++; if (order[2] !== 1) begin failures++; $display("FAIL rr_order2 got=%0d exp=1 (i0)", order[2]); end
        checks++; if (order[3] !== 3) begin failures++; $display("FAIL rr_order3 got=%0d exp=3 (i1)", order[3]); end
        checks++; if (multi !== 0) begin failures++; $display("FAIL rr_multi_grant got=%0d exp=0", multi); end
        checks++; if (addr_bad !== 0) begin failures++; $display("FAIL rr_addr_at_done got=%0d exp=0", addr_bad); end
        clear_reqs();
    endtask

    task automatic test_abandon();
        logic got;
        got = 1'b0;
        do_reset();
        ram_lat = 1;
        bus.dREN[0]  = 1'b1;
        bus.daddr[0] = 32'h500;
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            sample();
            if (!bus.dwait[0]) got = 1'b1;
            tick();
        end
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL ab_setup_done got=%0b exp=1 (cycle budget)", got); end
        // Now in the IDLE cycle after core 0 completed: rr points at core 1.
        bus.dREN[0]  = 1'b0;
        ram_lat      = 8;
        bus.dREN[1]  = 1'b1;
        bus.daddr[1] = 32'h600;
        sample();
        tick(); sample();
        checks++; if (bus.ramREN !== 1'b1) begin failures++; $display("FAIL ab_serve_ramREN got=%0b exp=1", bus.ramREN); end
        checks++; if (bus.ramaddr !== 32'h600) begin failures++; $display("FAIL ab_serve_addr got=%h exp=600", bus.ramaddr); end
        tick();
        bus.dREN[1] = 1'b0;
        sample();
        checks++; if (bus.dwait !== 2'b11) begin failures++; $display("FAIL ab_no_wait_drop got=%b exp=11", bus.dwait); end
        tick(); sample();
        checks++; if (bus.ramaddr !== 32'h0) begin failures++; $display("FAIL ab_idle_addr got=%h exp=0", bus.ramaddr); end
        tick();
        ram_lat      = 1;
        bus.dREN     = 2'b11;
        bus.daddr[0] = 32'h700;
        bus.daddr[1] = 32'h800;
        sample();
        tick(); sample();
        checks++; if (bus.ramaddr !== 32'h800) begin failures++; $display("FAIL ab_rr_kept got=%h exp=800", bus.ramaddr); end
        tick(); sample();
        checks++; if (bus.dwait !== 2'b01) begin failures++; $display("FAIL ab_after_dwait got=%b exp=01", bus.dwait); end
        tick();
        clear_reqs();
    endtask

    task automatic test_reset_mid_access();
        int done_at;
        done_at = -1;
        do_reset();
        ram_lat  = 3;
        ram_data = 32'h0BADF00D;
        bus.iREN[1]  = 1'b1;
        bus.iaddr[1] = 32'h900;
        sample();
        tick(); sample();
        checks++; if (bus.ramREN !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_ramREN got=%0b exp=1", bus.ramREN); end
        tick();
        nRST = 1'b0;
        #2;
        checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin failures++; $display("FAIL rst_mid_enables got=%b exp=00", {bus.ramREN, bus.ramWEN}); end
        checks++; if ({bus.iwait, bus.dwait} !== 4'b1111) begin failures++; $display("FAIL rst_mid_waits got=%b exp=1111", {bus.iwait, bus.dwait}); end
        checks++; if (bus.ramaddr !== 32'h0) begin failures++; $display("FAIL rst_mid_addr got=%h exp=0", bus.ramaddr); end
        tick();
        nRST = 1'b1;
        sample();
        checks++; if (bus.ramREN !== 1'b0) begin failures++; $display("FAIL rst_rel_idle_ramREN got=%0b exp=0", bus.ramREN); end
        tick(); sample();
        checks++; if (bus.ramaddr !== 32'h900) begin failures++; $display("FAIL rst_rel_serve_addr got=%h exp=900", bus.ramaddr); end
        for (int cyc = 1; cyc < 12 && done_at < 0; cyc++) begin
            tick(); sample();
            if (!bus.iwait[1]) begin
                done_at = cyc;
                checks++; if (bus.iload[1] !== 32'h0BADF00D) begin failures++; $display("FAIL rst_rel_iload got=%h exp=0badf00d", bus.iload[1]); end
            end
        end
        checks++; if (done_at !== 3) begin failures++; $display("FAIL rst_rel_done_cycle got=%0d exp=3", done_at); end
        tick();
        clear_reqs();
    endtask

    task automatic test_read_write_both();
        do_reset();
        ram_lat = 1;
        bus.dREN[0]   = 1'b1;
        bus.dWEN[0]   = 1'b1;
        bus.daddr[0]  = 32'hA0;
        bus.dstore[0] = 32'h55AA55AA;
        sample();
        tick(); sample();
        checks++; if ({bus.ramWEN, bus.ramREN} !== 2'b10) begin failures++; $display("FAIL rw_enables got=%b exp=10", {bus.ramWEN, bus.ramREN}); end
        checks++; if (bus.ramstore !== 32'h55AA55AA) begin failures++; $display("FAIL rw_store got=%h exp=55aa55aa", bus.ramstore); end
        tick(); sample();
        checks++; if (bus.dwait !== 2'b10) begin failures++; $display("FAIL rw_dwait got=%b exp=10", bus.dwait); end
        tick();
        clear_reqs();
    endtask

    task automatic test_error_hold();
        do_reset();
        ram_lat = 0;
        ram_err = 1'b1;
        bus.iREN[0]  = 1'b1;
        bus.iaddr[0] = 32'hB0;
        sample();
        tick(); tick(); sample();
        checks++; if (bus.ramREN !== 1'b1) begin failures++; $display("FAIL err_hold_ramREN got=%0b exp=1", bus.ramREN); end
        checks++; if (bus.iwait !== 2'b11) begin failures++; $display("FAIL err_hold_iwait got=%b exp=11", bus.iwait); end
        tick();
        ram_err = 1'b0;
        sample();
        checks++; if (bus.iwait !== 2'b10) begin failures++; $display("FAIL err_clear_iwait got=%b exp=10", bus.iwait); end
        tick();
        clear_reqs();
    endtask

    initial begin
        nRST = 1'b0;
        clear_reqs();
        test_reset();
        test_single_read();
        test_same_core_conflict();
        test_cross_core_fairness();
        test_abandon();
        test_reset_mid_access();
        test_read_write_both();
        test_error_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
